// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - MEM-stage load/store unit: req/ack data bus transaction, pipeline stall
// and big-endian load formatting between EX/MEM and MEM/WB.
module mem_lsu #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  wd_i,
   input  logic        wreg_i,
   input  logic [31:0] wdata_i,
   input  logic [3:0]  mem_op_i,
   input  logic [31:0] mem_addr_i,
   input  logic [31:0] mem_sdata_i,
   output logic [4:0]  mem_wd,
   output logic        mem_wreg,
   output logic [31:0] mem_wdata,
   output logic        stallreq,
   output logic        d_req,
   output logic        d_we,
   output logic [31:0] d_addr,
   output logic [3:0]  d_sel,
   output logic [31:0] d_wdata,
   input  logic        d_ack,
   input  logic [31:0] d_rdata,
   output logic        misalign,
   output logic        bus_err
);

   localparam logic [3:0] OP_NONE = 4'd0;
   localparam logic [3:0] OP_LB   = 4'd1;
   localparam logic [3:0] OP_LBU  = 4'd2;
   localparam logic [3:0] OP_LH   = 4'd3;
   localparam logic [3:0] OP_LHU  = 4'd4;
   localparam logic [3:0] OP_LW   = 4'd5;
   localparam logic [3:0] OP_SB   = 4'd6;
   localparam logic [3:0] OP_SH   = 4'd7;
   localparam logic [3:0] OP_SW   = 4'd8;
   localparam logic [7:0] C_LAST  = 8'(TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

   state_t      r_state;
   state_t      w_next;
   logic [7:0]  r_cnt;
   logic [31:0] r_ldata;
   logic        r_tmo;

   logic [3:0]  w_op;
   logic        w_load;
   logic        w_store;
   logic        w_byte;
   logic        w_half;
   logic        w_word;
   logic        w_misal;
   logic        w_timeout;
   logic [7:0]  w_lbyte;
   logic [15:0] w_lhalf;
   logic [31:0] w_fmt;

   // While reset is held the incoming op is masked so every output follows the idle pass-through.
   assign w_op      = rst ? mem_op_i : OP_NONE;
   assign w_load    = (w_op >= OP_LB) && (w_op <= OP_LW);
   assign w_store   = (w_op >= OP_SB) && (w_op <= OP_SW);
   assign w_byte    = (w_op == OP_LB) || (w_op == OP_LBU) || (w_op == OP_SB);
   assign w_half    = (w_op == OP_LH) || (w_op == OP_LHU) || (w_op == OP_SH);
   assign w_word    = (w_op == OP_LW) || (w_op == OP_SW);
   assign w_misal   = (w_half && mem_addr_i[0]) || (w_word && (mem_addr_i[1:0] != 2'b00));
   assign w_timeout = (r_state == S_WAIT) && !d_ack && (r_cnt == C_LAST);
   assign d_addr    = {mem_addr_i[31:2], 2'b00};

   always_comb begin
      d_sel   = 4'b0000;
      d_wdata = mem_sdata_i;
      if (w_byte) begin
         d_sel   = 4'b1000 >> mem_addr_i[1:0];
         d_wdata = {4{mem_sdata_i[7:0]}};
      end else if (w_half) begin
         d_sel   = mem_addr_i[1] ? 4'b0011 : 4'b1100;
         d_wdata = {2{mem_sdata_i[15:0]}};
      end else if (w_word) begin
         d_sel   = 4'b1111;
      end
   end

   // Lane 0 (addr[1:0]=0) is the most significant byte.
   always_comb begin
      w_lbyte = d_rdata[31:24];
      case (mem_addr_i[1:0])
         2'd1:    w_lbyte = d_rdata[23:16];
         2'd2:    w_lbyte = d_rdata[15:8];
         2'd3:    w_lbyte = d_rdata[7:0];
         default: w_lbyte = d_rdata[31:24];
      endcase
      w_lhalf = mem_addr_i[1] ? d_rdata[15:0] : d_rdata[31:16];
      case (w_op)
         OP_LB:   w_fmt = {{24{w_lbyte[7]}}, w_lbyte};
         OP_LBU:  w_fmt = {24'h000000, w_lbyte};
         OP_LH:   w_fmt = {{16{w_lhalf[15]}}, w_lhalf};
         OP_LHU:  w_fmt = {16'h0000, w_lhalf};
         default: w_fmt = d_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_cnt   <= 8'd0;
         r_ldata <= 32'd0;
         r_tmo   <= 1'b0;
      end else begin
         r_state <= w_next;
         case (r_state)
            S_IDLE: begin
               r_cnt <= 8'd0;
               r_tmo <= 1'b0;
            end
            S_WAIT: begin
               if (d_ack) begin
                  r_ldata <= w_fmt;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
               if (w_timeout) begin
                  r_tmo <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      w_next    = r_state;
      mem_wd    = wd_i;
      mem_wreg  = wreg_i;
      mem_wdata = wdata_i;
      stallreq  = 1'b0;
      d_req     = 1'b0;
      d_we      = 1'b0;
      misalign  = 1'b0;
      bus_err   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_load || w_store) begin
               mem_wreg = 1'b0;
               if (w_misal) begin
                  misalign = 1'b1;
               end else begin
                  stallreq = 1'b1;
                  w_next   = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            d_req    = 1'b1;
            d_we     = w_store;
            stallreq = 1'b1;
            mem_wreg = 1'b0;
            if (d_ack) begin
               w_next = S_DONE;
            end else if (w_timeout) begin
               bus_err = 1'b1;
               w_next  = S_DONE;
            end
         end
         S_DONE: begin
            w_next = S_IDLE;
            if (w_load) begin
               mem_wdata = r_ldata;
               mem_wreg  = wreg_i && !r_tmo;
            end else if (w_store) begin
               mem_wreg  = 1'b0;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

endmodule
